// File: rtl/argmax_pkg.sv
// Shared sizing for the 16-input signed argmax tree.
// Pure declarations: no latency, no flow control.
package argmax_pkg;
    localparam int N_INPUTS = 16;
    localparam int IDX_W    = 4;
    localparam int N_LEVEL1 = N_INPUTS / 2;
    localparam int N_LEVEL2 = N_INPUTS / 4;

    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/argmax_node2.sv
// Two-way signed compare node forwarding the winning {value, index}; lower index wins ties.
// Combinational, zero latency; no flow control.
module argmax_node2
    import argmax_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic signed [WIDTH-1:0] a_val,
    input  idx_t                    a_idx,
    input  logic signed [WIDTH-1:0] b_val,
    input  idx_t                    b_idx,
    output logic signed [WIDTH-1:0] win_val,
    output idx_t                    win_idx
);

    logic b_wins;

    assign b_wins  = (b_val > a_val) || ((b_val == a_val) && (b_idx < a_idx));
    assign win_val = b_wins ? b_val : a_val;
    assign win_idx = b_wins ? b_idx : a_idx;

endmodule

// File: rtl/parallel_argmax_signed_16in.sv
// Max and argmax of 16 signed elements through a 4-level comparator tree.
// Latency 1 (MID_PIPE=0) or 2 (MID_PIPE=1); one vector per cycle, no back-pressure.
module parallel_argmax_signed_16in
    import argmax_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int MID_PIPE = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [N_INPUTS*WIDTH-1:0]   in,
    output logic                        out_valid,
    output logic signed [WIDTH-1:0]     max,
    output logic [IDX_W-1:0]            argmax
);

    logic signed [WIDTH-1:0] v1 [N_LEVEL1];
    idx_t                    i1 [N_LEVEL1];
    logic signed [WIDTH-1:0] v2 [N_LEVEL2];
    idx_t                    i2 [N_LEVEL2];
    logic signed [WIDTH-1:0] v2q [N_LEVEL2];
    idx_t                    i2q [N_LEVEL2];
    logic signed [WIDTH-1:0] v3 [2];
    idx_t                    i3 [2];
    logic signed [WIDTH-1:0] v4;
    idx_t                    i4;
    logic                    mid_valid;

    for (genvar g = 0; g < N_LEVEL1; g++) begin : g_lvl1
        argmax_node2 #(.WIDTH(WIDTH)) u_node (
            .a_val   (in[(2*g)*WIDTH +: WIDTH]),
            .a_idx   (idx_t'(2*g)),
            .b_val   (in[(2*g+1)*WIDTH +: WIDTH]),
            .b_idx   (idx_t'(2*g+1)),
            .win_val (v1[g]),
            .win_idx (i1[g])
        );
    end

    for (genvar g = 0; g < N_LEVEL2; g++) begin : g_lvl2
        argmax_node2 #(.WIDTH(WIDTH)) u_node (
            .a_val   (v1[2*g]),
            .a_idx   (i1[2*g]),
            .b_val   (v1[2*g+1]),
            .b_idx   (i1[2*g+1]),
            .win_val (v2[g]),
            .win_idx (i2[g])
        );
    end

    // Optional cut after level 2 splits the tree roughly in half for timing.
    if (MID_PIPE != 0) begin : g_mid
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mid_valid <= 1'b0;
                v2q       <= '{default: '0};
                i2q       <= '{default: '0};
            end else begin
                mid_valid <= in_valid;
                if (in_valid) begin
                    v2q <= v2;
                    i2q <= i2;
                end
            end
        end
    end else begin : g_no_mid
        assign mid_valid = in_valid;
        assign v2q       = v2;
        assign i2q       = i2;
    end

    for (genvar g = 0; g < 2; g++) begin : g_lvl3
        argmax_node2 #(.WIDTH(WIDTH)) u_node (
            .a_val   (v2q[2*g]),
            .a_idx   (i2q[2*g]),
            .b_val   (v2q[2*g+1]),
            .b_idx   (i2q[2*g+1]),
            .win_val (v3[g]),
            .win_idx (i3[g])
        );
    end

    argmax_node2 #(.WIDTH(WIDTH)) u_lvl4 (
        .a_val   (v3[0]),
        .a_idx   (i3[0]),
        .b_val   (v3[1]),
        .b_idx   (i3[1]),
        .win_val (v4),
        .win_idx (i4)
    );

    // Results hold across idle cycles; only a qualified stage updates them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            max       <= '0;
            argmax    <= '0;
        end else begin
            out_valid <= mid_valid;
            if (mid_valid) begin
                max    <= v4;
                argmax <= i4;
            end
        end
    end

endmodule

// File: tb/tb_parallel_argmax_signed_16in.sv
// Drives both latency variants with the same stream and checks them against an argmax reference.
module tb_parallel_argmax_signed_16in;
    localparam int W = 5;
    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [N*W-1:0] in_vec = '0;

    logic           out_valid0, out_valid1;
    logic [W-1:0]   max0, max1;
    logic [3:0]     argmax0, argmax1;

    int n_assert = 0;
    int n_fail   = 0;

    // expected outputs of each instance, plus the vector still in flight for the 2-cycle one
    int e0v = 0, e0m = 0, e0i = 0;
    int e1v = 0, e1m = 0, e1i = 0;
    int pv = 0, pm = 0, pi = 0;

    always #5 clk = ~clk;

    parallel_argmax_signed_16in #(.WIDTH(W), .MID_PIPE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in_vec),
        .out_valid(out_valid0), .max(max0), .argmax(argmax0)
    );

    parallel_argmax_signed_16in #(.WIDTH(W), .MID_PIPE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in_vec),
        .out_valid(out_valid1), .max(max1), .argmax(argmax1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_argmax(input logic [N*W-1:0] vec, output int m, output int idx);
        int v;
        m   = -(1 << 30);
        idx = 0;
        for (int i = 0; i < N; i++) begin
            v = $signed(vec[i*W +: W]);
            if (v > m) begin
                m   = v;
                idx = i;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".out_valid0"}, int'(out_valid0), e0v);
        chk({tag, ".max0"}, int'($signed(max0)), e0m);
        chk({tag, ".argmax0"}, int'(argmax0), e0i);
        chk({tag, ".out_valid1"}, int'(out_valid1), e1v);
        chk({tag, ".max1"}, int'($signed(max1)), e1m);
        chk({tag, ".argmax1"}, int'(argmax1), e1i);
    endtask

    task automatic step(input string tag, input logic [N*W-1:0] vec, input logic v);
        int rm, ri;
        @(negedge clk);
        in_vec   = vec;
        in_valid = v;
        ref_argmax(vec, rm, ri);
        @(posedge clk);
        #1;
        e0v = int'(v);
        if (v) begin
            e0m = rm;
            e0i = ri;
        end
        e1v = pv;
        if (pv != 0) begin
            e1m = pm;
            e1i = pi;
        end
        pv = int'(v);
        pm = rm;
        pi = ri;
        check_all(tag);
    endtask

    function automatic logic [N*W-1:0] rand_vec(input bit narrow);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++)
            r[i*W +: W] = narrow ? W'($urandom_range(0, 2) + 14) : W'($urandom);
        return r;
    endfunction

    initial begin
        logic [N*W-1:0] vec;

        #3;
        check_all("reset");
        #9 rst_n = 1'b1;

        for (int i = 0; i < N; i++) vec[i*W +: W] = W'(15 - i);
        step("descending", vec, 1'b1);
        for (int i = 0; i < N; i++) vec[i*W +: W] = W'(i - 16);
        step("asc_neg", vec, 1'b1);
        for (int i = 0; i < N; i++) vec[i*W +: W] = W'(-3);
        step("all_m3", vec, 1'b1);
        for (int i = 0; i < N; i++) vec[i*W +: W] = W'(-16);
        vec[9*W +: W]  = W'(1);
        vec[12*W +: W] = W'(1);
        step("two_ones", vec, 1'b1);
        vec = '0;
        vec[5*W +: W] = W'(-1);
        step("zeros", vec, 1'b1);
        for (int k = 0; k < 3; k++) step("idle_hold", rand_vec(1'b0), 1'b0);

        // asynchronous reset while a result is being presented and another is in flight
        for (int i = 0; i < N; i++) vec[i*W +: W] = W'(15 - i);
        step("pre_reset_a", vec, 1'b1);
        step("pre_reset_b", rand_vec(1'b0), 1'b1);
        rst_n = 1'b0;
        #1;
        e0v = 0; e0m = 0; e0i = 0;
        e1v = 0; e1m = 0; e1i = 0;
        pv = 0;  pm = 0;  pi = 0;
        check_all("async_reset");
        #2 rst_n = 1'b1;
        vec = '0;
        vec[7*W +: W] = W'(4);
        step("post_reset", vec, 1'b1);
        step("post_reset_idle", rand_vec(1'b0), 1'b0);

        for (int k = 0; k < 80; k++)
            step("random", rand_vec(k[0]), ($urandom_range(0, 3) != 0));
        step("drain_a", rand_vec(1'b0), 1'b0);
        step("drain_b", rand_vec(1'b0), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/parallel_argmax_signed_16in.md
Name: parallel_argmax_signed_16in

Overview:
- Finds the maximum of 16 signed WIDTH-bit values presented in parallel, and the index of that maximum.
- Uses a 4-level balanced comparator tree. The result is registered, and an optional mid-tree pipeline register can be enabled.
- Used in classifier/decision back-ends, for example picking the winning logit.

Parameters:
- WIDTH, 5, bit width of each signed input element and of max.
- MID_PIPE, 0, 0 = single output register (latency 1); 1 = extra register after tree level 2 (latency 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies the in vector this cycle
- in  input  16*WIDTH  packed signed elements; element i occupies bits [i*WIDTH +: WIDTH]
- out_valid  output  1  max/argmax hold a new result this cycle
- max  output  WIDTH  signed maximum of the 16 elements
- argmax  output  4  index (0..15) of the maximum element

Behaviour:
- Reset (rst_n low, asynchronous):
  - max, argmax, out_valid and all internal pipeline registers clear to 0 immediately.
  - Registers release on the first clk edge after rst_n goes high.
- Comparison:
  - All elements are two's-complement signed; compare signed, never unsigned. Example: -1 < 0; -16 (5'b10000) is the minimum for WIDTH=5.
  - No widening or arithmetic is needed; max equals the selected element bit-exactly.
- Tree structure:
  - Level 1 pairs (0,1),(2,3)…(14,15); level 2 pairs the level-1 winners; and so on, 4 levels total.
  - Each node forwards the winning value and its 4-bit index.
- Tie-break:
  - On equal values, the lower-index operand wins at every node.
  - Globally, the lowest index among equal maxima is reported.
- Latency, MID_PIPE=0:
  - The tree is combinational from in to the output register.
  - The result for a vector accepted at edge k appears on max/argmax after edge k, with out_valid=1 for that cycle.
- Latency, MID_PIPE=1:
  - The four level-2 winners (value + index) are registered, then the output is registered.
  - Latency is 2 cycles.
- Throughput: one vector per cycle, with no back-pressure and no ready signal.
- Valid pipeline:
  - out_valid is in_valid delayed by the latency.
  - Data registers load only when the valid entering that stage is 1; otherwise they hold.
  - When in_valid is low, max/argmax keep the last result and out_valid=0.
- X-safety: an in_valid=0 cycle must never corrupt held results.
- Reset mid-operation: in-flight results are discarded and out_valid drops to 0 asynchronously.

Decomposition:
- Package argmax_pkg:
  - localparam N_INPUTS=16, IDX_W=4.
  - Helper function/typedef for a {value, index} pair is optional.
- Sub-module argmax_node2:
  - Combinational; inputs two (signed value, index) pairs; outputs the winning pair.
  - Lower index wins on tie.
  - Instantiated 15 times via generate.
- Top-level contains the generate tree, optional mid register, output register and valid pipe.

Test Plan:
- Descending order, WIDTH=5, in[i]=15-i, in_valid=1 one cycle -> next cycle max=15, argmax=0, out_valid=1.
- Ascending negatives, in[i]=i-16 (-16..-1) -> max=-1, argmax=15; checks signed comparison.
- All elements -3 -> max=-3, argmax=0 (tie resolves to lowest index).
- All -16 except in[9]=1 and in[12]=1 -> max=1, argmax=9. Then a vector with all 0 except in[5]=-1 -> max=0, argmax=0.
- Back-to-back vectors every cycle (as above), then in_valid=0 for 3 cycles:
  - Results arrive one per cycle in order.
  - Afterwards out_valid=0 and max/argmax hold the last result.
  - Repeat with MID_PIPE=1 and check a 2-cycle latency.
- Assert rst_n low between clock edges while out_valid=1 -> max, argmax and out_valid are 0 before the next edge; the first valid after release yields the correct result.
